// File: rtl/pll_ctrl_pkg.sv
// Shared types and widths for the PLL dynamic-configuration controller.
package pll_ctrl_pkg;

    localparam int unsigned DSEL_W  = 6;
    localparam int unsigned RETRY_W = 4;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        STABLE,
        READY,
        FAIL
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous status bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// PLL sequencer: holds reset, applies divider selects, qualifies lock and
// reports clk_ready; retries on lock timeout and recovers on loss of lock.
module pll_dyn_cfg_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned       RST_CYCLES    = 16,
    parameter int unsigned       LOCK_TIMEOUT  = 65535,
    parameter int unsigned       STABLE_CYCLES = 1024,
    parameter int unsigned       MAX_RETRY     = 3,
    parameter logic [DSEL_W-1:0] DEF_IDSEL     = 6'd0,
    parameter logic [DSEL_W-1:0] DEF_FBDSEL    = 6'd0,
    parameter logic [DSEL_W-1:0] DEF_ODSEL     = 6'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_req,
    input  logic [DSEL_W-1:0]  cfg_idsel,
    input  logic [DSEL_W-1:0]  cfg_fbdsel,
    input  logic [DSEL_W-1:0]  cfg_odsel,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [DSEL_W-1:0]  pll_idsel,
    output logic [DSEL_W-1:0]  pll_fbdsel,
    output logic [DSEL_W-1:0]  pll_odsel,
    output logic               busy,
    output logic               clk_ready,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic               lol_event,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned T_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int unsigned T_MAX  = (T_MAX0 > RST_CYCLES) ? T_MAX0 : RST_CYCLES;
    localparam int unsigned TW     = $clog2(T_MAX) + 1;

    localparam logic [TW-1:0]      RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]      LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]      STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    state_t        state;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          lock_s;
    logic          accept;
    logic          lol;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Saturating timer increment plus the two restart conditions; a request
    // in READY takes priority over a simultaneous loss of lock.
    always_comb begin
        timer_inc = (timer == '1) ? timer : timer + 1'b1;
        accept    = cfg_req && ((state == READY) || (state == FAIL));
        lol       = (state == READY) && !lock_s && !cfg_req;
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RST_HOLD;
            timer      <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= DEF_IDSEL;
            pll_fbdsel <= DEF_FBDSEL;
            pll_odsel  <= DEF_ODSEL;
            busy       <= 1'b1;
            clk_ready  <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            lol_event  <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            lol_event <= 1'b0;
            if (accept || lol) begin
                // Both restarts share one path; only a request changes selects.
                if (accept) begin
                    pll_idsel  <= cfg_idsel;
                    pll_fbdsel <= cfg_fbdsel;
                    pll_odsel  <= cfg_odsel;
                end
                lol_event <= lol;
                state     <= RST_HOLD;
                timer     <= '0;
                pll_reset <= 1'b1;
                busy      <= 1'b1;
                clk_ready <= 1'b0;
                retry_cnt <= '0;
            end else begin
                case (state)
                    RST_HOLD: begin
                        if (timer == RST_LAST) begin
                            state     <= WAIT_LOCK;
                            timer     <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                            timer <= '0;
                        end else if (timer == LOCK_LAST) begin
                            timer     <= '0;
                            pll_reset <= 1'b1;
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= RST_HOLD;
                            end else begin
                                state   <= FAIL;
                                busy    <= 1'b0;
                                cfg_err <= 1'b1;
                            end
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            timer <= '0;
                        end else if (timer == STABLE_LAST) begin
                            state     <= READY;
                            timer     <= '0;
                            busy      <= 1'b0;
                            clk_ready <= 1'b1;
                            cfg_done  <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                    READY, FAIL: begin
                    end
                    default: begin
                        state     <= RST_HOLD;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        busy      <= 1'b1;
                        clk_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Self-checking bench for pll_dyn_cfg_ctrl against a phase/timestamp model.
module tb_pll_dyn_cfg_ctrl;

    localparam int RST_CYC = 4;
    localparam int LOCK_TO = 20;
    localparam int STB_CYC = 8;
    localparam int MAX_R   = 2;
    localparam logic [5:0] D_ID = 6'd3;
    localparam logic [5:0] D_FB = 6'd17;
    localparam logic [5:0] D_OD = 6'd1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RDY  = 3;
    localparam int P_FAIL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = '0;
    logic [5:0] cfg_fbdsel = '0;
    logic [5:0] cfg_odsel = '0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       busy;
    logic       clk_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic       lol_event;
    logic [3:0] retry_cnt;

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES    (RST_CYC),
        .LOCK_TIMEOUT  (LOCK_TO),
        .STABLE_CYCLES (STB_CYC),
        .MAX_RETRY     (MAX_R),
        .DEF_IDSEL     (D_ID),
        .DEF_FBDSEL    (D_FB),
        .DEF_ODSEL     (D_OD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .busy       (busy),
        .clk_ready  (clk_ready),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .lol_event  (lol_event),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_done_seen = 0;
    int n_err_seen  = 0;
    int n_lol_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase plus the edge index at which it was entered;
    // lock is seen through a two-edge delay line.
    int         edge_n   = 0;
    int         ph       = P_RST;
    int         ph_since = 0;
    int         m_retry  = 0;
    logic [5:0] m_id = D_ID, m_fb = D_FB, m_od = D_OD;
    bit         m_done, m_err, m_lol;
    bit         lockq[$];

    function automatic void enter(input int p);
        ph       = p;
        ph_since = edge_n;
    endfunction

    task automatic model_edge(input bit r, input bit req, input logic [5:0] id,
                              input logic [5:0] fb, input logic [5:0] od, input bit lk);
        bit ls;
        int idx;
        edge_n++;
        m_done = 0;
        m_err  = 0;
        m_lol  = 0;
        if (r) begin
            enter(P_RST);
            m_retry = 0;
            m_id = D_ID; m_fb = D_FB; m_od = D_OD;
            lockq.delete();
            return;
        end
        ls = (lockq.size() >= 2) ? lockq[lockq.size() - 2] : 1'b0;
        lockq.push_back(lk);
        if (lockq.size() > 2) void'(lockq.pop_front());
        idx = edge_n - ph_since - 1;
        case (ph)
            P_RST:  if (idx == RST_CYC - 1) enter(P_WAIT);
            P_WAIT: begin
                if (ls) enter(P_STB);
                else if (idx == LOCK_TO - 1) begin
                    if (m_retry < MAX_R) begin m_retry++; enter(P_RST); end
                    else begin enter(P_FAIL); m_err = 1; end
                end
            end
            P_STB: begin
                if (!ls) enter(P_WAIT);
                else if (idx == STB_CYC - 1) begin enter(P_RDY); m_done = 1; m_retry = 0; end
            end
            default: begin
                if (req) begin
                    m_id = id; m_fb = fb; m_od = od;
                    m_retry = 0;
                    enter(P_RST);
                end else if (ph == P_RDY && !ls) begin
                    m_lol = 1;
                    m_retry = 0;
                    enter(P_RST);
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(rst, cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel, pll_lock);
        #1;
        chk("pll_reset", 32'(pll_reset), 32'(ph == P_RST || ph == P_FAIL));
        chk("busy",      32'(busy),      32'(!(ph == P_RDY || ph == P_FAIL)));
        chk("clk_ready", 32'(clk_ready), 32'(ph == P_RDY));
        chk("idsel",     32'(pll_idsel),  32'(m_id));
        chk("fbdsel",    32'(pll_fbdsel), 32'(m_fb));
        chk("odsel",     32'(pll_odsel),  32'(m_od));
        chk("cfg_done",  32'(cfg_done),  32'(m_done));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
        chk("lol_event", 32'(lol_event), 32'(m_lol));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        if (cfg_done)  n_done_seen++;
        if (cfg_err)   n_err_seen++;
        if (lol_event) n_lol_seen++;
        cfg_req = 1'b0;
    endtask

    task automatic req(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        cfg_req    = 1'b1;
        cfg_idsel  = a;
        cfg_fbdsel = b;
        cfg_odsel  = c;
        cycle();
    endtask

    task automatic req_rand();
        req(6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic wait_phase(input int p, input int budget, input string tag);
        int n = 0;
        while (ph != p && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(ph == p), 32'd1);
    endtask

    initial begin
        // Boot with lock arriving ten cycles after reset release
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        n_done_seen = 0;
        repeat (9) cycle();
        pll_lock = 1'b1;
        wait_phase(P_RDY, 100, "boot_ready");
        cycle();
        chk("boot_done_cnt", 32'(n_done_seen), 32'd1);

        // No lock at all: loss of lock, then retries exhaust into FAIL
        pll_lock = 1'b0;
        n_err_seen = 0;
        repeat (4) cycle();
        wait_phase(P_FAIL, 200, "reach_fail");
        repeat (5) cycle();
        chk("fail_err_cnt", 32'(n_err_seen), 32'd1);

        // Recover from FAIL, then reconfigure from READY, with a request while busy
        pll_lock = 1'b1;
        req_rand();
        wait_phase(P_RDY, 100, "fail_recover");
        req(6'd5, 6'd12, 6'd8);
        repeat (2) cycle();
        req_rand();
        wait_phase(P_RDY, 100, "reconfig_ready");
        chk("reconfig_idsel", 32'(pll_idsel), 32'd5);

        // Two-cycle lock glitch inside STABLE
        req_rand();
        wait_phase(P_STB, 100, "reach_stable");
        repeat (5) cycle();
        pll_lock = 1'b0;
        repeat (2) cycle();
        pll_lock = 1'b1;
        repeat (3) cycle();
        wait_phase(P_RDY, 100, "glitch_ready");

        // Single-cycle loss of lock while READY
        n_lol_seen = 0;
        pll_lock = 1'b0;
        cycle();
        pll_lock = 1'b1;
        repeat (3) cycle();
        wait_phase(P_RDY, 100, "lol_ready");
        chk("lol_cnt", 32'(n_lol_seen), 32'd1);

        // Loss of lock coinciding with a request: request wins
        n_lol_seen = 0;
        pll_lock = 1'b0;
        cycle();
        pll_lock = 1'b1;
        cycle();
        req_rand();
        wait_phase(P_RDY, 100, "lol_req_ready");
        chk("lol_req_cnt", 32'(n_lol_seen), 32'd0);

        // Reset during WAIT_LOCK after a select change
        pll_lock = 1'b0;
        req(6'd40, 6'd41, 6'd42);
        wait_phase(P_WAIT, 50, "reach_wait");
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_idsel", 32'(pll_idsel), 32'(D_ID));

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, pll_lock ? 60 : 6) == 0) pll_lock = ~pll_lock;
            if ($urandom_range(0, 25) == 0) begin
                cfg_req    = 1'b1;
                cfg_idsel  = 6'($urandom);
                cfg_fbdsel = 6'($urandom);
                cfg_odsel  = 6'($urandom);
            end
            rst = ($urandom_range(0, 700) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
